// File: rtl/sdr_lb_initiator.sv
// Local-bus initiator for the SDR SDRAM controller: issues one burst at a time,
// streams write data from a FWFT source, captures read data and flags done/timeout.
module sdr_lb_initiator #(
  parameter int unsigned SDRAM_RASIZE = 31,
  parameter int unsigned DW           = 16,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_RNW,
  input  logic [SDRAM_RASIZE-1:0] CMD_ADDR,
  input  logic [3:0]              CMD_BSIZE,
  input  logic                    CMD_AUTOPCH,
  input  logic [DW-1:0]           WD_IN,
  output logic                    WD_POP,
  input  logic [DW-1:0]           DQ_IN,
  output logic [DW-1:0]           DQ_OUT,
  output logic [DW-1:0]           RD_OUT,
  output logic                    RD_PUSH,
  output logic [SDRAM_RASIZE-1:0] RADDR,
  output logic                    R_REQ,
  output logic                    W_REQ,
  output logic [3:0]              B_SIZE,
  output logic                    AUTO_PCH,
  input  logic                    RW_ACK,
  input  logic                    D_REQ,
  input  logic                    W_VALID,
  input  logic                    R_VALID,
  output logic                    DONE,
  output logic                    ERR
);

  typedef enum logic [1:0] {StIdle, StReq, StWdata, StRdata} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [SDRAM_RASIZE-1:0] raddr_q, raddr_d;
  logic [3:0]              bsize_q, bsize_d;
  logic                    autopch_q, autopch_d;
  logic                    rreq_q, rreq_d, wreq_q, wreq_d;
  logic [DW-1:0]           dq_out_q, dq_out_d, rd_out_q, rd_out_d;
  logic                    rd_push_q, rd_push_d, done_q, done_d, err_q, err_d;
  logic [3:0]              popped_q, popped_d, beats_q, beats_d;
  logic [15:0]             idle_cnt_q, idle_cnt_d;
  logic                    accept, wd_pop, progress;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Gating on done_q defers a new command issued alongside DONE by one cycle.
  assign CMD_READY = (state_q == StIdle) && !done_q;
  assign accept    = CMD_VALID && CMD_READY;
  assign wd_pop    = (state_q == StWdata) && D_REQ && (popped_q < bsize_q);
  assign progress  = (state_q != StIdle) && (RW_ACK || wd_pop || W_VALID || R_VALID);

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    bsize_d    = bsize_q;
    autopch_d  = autopch_q;
    rreq_d     = rreq_q;
    wreq_d     = wreq_q;
    dq_out_d   = dq_out_q;
    rd_out_d   = rd_out_q;
    rd_push_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    popped_d   = popped_q;
    beats_d    = beats_q;
    idle_cnt_d = idle_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (CMD_BSIZE == 4'd0) begin
            err_d = 1'b1;
          end else begin
            raddr_d   = CMD_ADDR;
            bsize_d   = CMD_BSIZE;
            autopch_d = CMD_AUTOPCH;
            rreq_d    = CMD_RNW;
            wreq_d    = !CMD_RNW;
            popped_d  = 4'd0;
            beats_d   = 4'd0;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        if (RW_ACK) begin
          rreq_d  = 1'b0;
          wreq_d  = 1'b0;
          state_d = rreq_q ? StRdata : StWdata;
        end
      end
      StWdata: begin
        if (wd_pop) begin
          dq_out_d = WD_IN;
          popped_d = sat_inc(popped_q);
        end
        if (W_VALID && (beats_q < bsize_q)) begin
          beats_d = sat_inc(beats_q);
          if ((beats_q + 4'd1) == bsize_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRdata: begin
        if (R_VALID && (beats_q < bsize_q)) begin
          rd_out_d  = DQ_IN;
          rd_push_d = 1'b1;
          beats_d   = sat_inc(beats_q);
          if ((beats_q + 4'd1) == bsize_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Stall watchdog: abort without DONE once TIMEOUT cycles pass with no progress.
    if ((state_q != StIdle) && !progress && (idle_cnt_q == TimeoutLast)) begin
      rreq_d  = 1'b0;
      wreq_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = StIdle;
    end

    if ((state_q == StIdle) || (state_d != state_q) || progress) begin
      idle_cnt_d = 16'd0;
    end else if (idle_cnt_q != 16'hFFFF) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      raddr_q    <= '0;
      bsize_q    <= '0;
      autopch_q  <= 1'b0;
      rreq_q     <= 1'b0;
      wreq_q     <= 1'b0;
      dq_out_q   <= '0;
      rd_out_q   <= '0;
      rd_push_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      popped_q   <= '0;
      beats_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      bsize_q    <= bsize_d;
      autopch_q  <= autopch_d;
      rreq_q     <= rreq_d;
      wreq_q     <= wreq_d;
      dq_out_q   <= dq_out_d;
      rd_out_q   <= rd_out_d;
      rd_push_q  <= rd_push_d;
      done_q     <= done_d;
      err_q      <= err_d;
      popped_q   <= popped_d;
      beats_q    <= beats_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign WD_POP   = wd_pop;
  assign DQ_OUT   = dq_out_q;
  assign RD_OUT   = rd_out_q;
  assign RD_PUSH  = rd_push_q;
  assign RADDR    = raddr_q;
  assign R_REQ    = rreq_q;
  assign W_REQ    = wreq_q;
  assign B_SIZE   = bsize_q;
  assign AUTO_PCH = autopch_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: doc/sdr_lb_initiator.md
Name: sdr_lb_initiator

Overview:
- Local-bus initiator for the SDR SDRAM controller top level. It drives the controller's request side (RADDR, R_REQ, W_REQ, B_SIZE, AUTO_PCH) and consumes its handshakes (RW_ACK, D_REQ, W_VALID, R_VALID).
- Upstream logic issues one burst command at a time through a valid/ready port.
- The block sources write data from a first-word-fall-through (FWFT) stream, captures read data from the SDRAM DQ pads, counts beats, and reports completion or timeout.

Parameters:
- SDRAM_RASIZE, 31, width of CMD_ADDR and RADDR.
- DW, 16, data width.
- TIMEOUT, 1023, maximum number of cycles without progress in any non-IDLE state before the command is aborted. Legal range is 1 to 65535.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when both CMD_VALID and CMD_READY are high.
- CMD_RNW  in  1  1 = read, 0 = write.
- CMD_ADDR  in  SDRAM_RASIZE  burst start address.
- CMD_BSIZE  in  4  beat count. Legal values are 1 to 15.
- CMD_AUTOPCH  in  1  autoprecharge request.
- WD_IN  in  DW  FWFT write data head.
- WD_POP  out  1  consumes WD_IN this cycle.
- DQ_IN  in  DW  SDRAM read data from the pads.
- DQ_OUT  out  DW  SDRAM write data to the pads.
- RD_OUT  out  DW  captured read word.
- RD_PUSH  out  1  RD_OUT valid, one-cycle pulse.
- RADDR  out  SDRAM_RASIZE  controller address.
- R_REQ  out  1  read request.
- W_REQ  out  1  write request.
- B_SIZE  out  4  controller burst size.
- AUTO_PCH  out  1  controller autoprecharge.
- RW_ACK  in  1  controller acknowledge.
- D_REQ  in  1  controller write-data request.
- W_VALID  in  1  controller write beat consumed.
- R_VALID  in  1  controller read beat valid.
- DONE  out  1  one-cycle pulse when a burst completes.
- ERR  out  1  one-cycle pulse on an illegal command or a timeout.

Behaviour:
- Reset: all outputs are 0, except CMD_READY, which is 1. The state is IDLE and all counters are 0.
- States are IDLE, REQ, WDATA, RDATA.
- IDLE:
  - CMD_READY = 1.
  - On accept with CMD_BSIZE = 0: no request is issued, ERR pulses on the next cycle, and the state stays IDLE.
  - On accept with a legal CMD_BSIZE: RADDR, B_SIZE and AUTO_PCH are registered and held stable until the block returns to IDLE. R_REQ or W_REQ rises on the next cycle, selected by CMD_RNW. The state moves to REQ.
- REQ:
  - The request is held until RW_ACK is sampled high.
  - On that edge the request is cleared, so R_REQ/W_REQ is low in the following cycle.
  - The state then moves to RDATA or WDATA.
  - RW_ACK, D_REQ and R_VALID seen in IDLE are ignored.
- WDATA:
  - WD_POP = D_REQ && (popped < B_SIZE), driven combinationally.
  - On a pop, DQ_OUT is loaded with WD_IN on the same edge and popped increments.
  - D_REQ beyond B_SIZE beats causes no pop and DQ_OUT holds its value.
  - Each W_VALID increments written.
  - When written reaches B_SIZE: DONE pulses on the next cycle and the state returns to IDLE.
  - W_VALID beyond the count is ignored.
- RDATA:
  - On R_VALID, RD_OUT is loaded with DQ_IN, RD_PUSH pulses on the next cycle, and the beat counter increments.
  - After the B_SIZE-th beat: DONE pulses in the same cycle as the last RD_PUSH, and the state returns to IDLE.
  - R_VALID in WDATA or REQ is ignored.
- Timeout:
  - A 16-bit idle counter resets on state entry and on any RW_ACK, pop, W_VALID or R_VALID. It increments otherwise.
  - When it reaches TIMEOUT: requests are dropped, ERR pulses, no DONE is issued, and the state returns to IDLE. Partial read beats already pushed stand.
- Simultaneous events:
  - RW_ACK together with D_REQ in the same cycle: RW_ACK is processed and D_REQ is ignored. The controller never issues D_REQ before acknowledging.
  - DONE and a new CMD_VALID in the same cycle: the new command is accepted only on the following cycle, once the block is in IDLE.
- Counters are 4-bit and saturate at 15; they never wrap.
- Reset asserted mid-burst clears everything immediately (asynchronous). No DONE or ERR is issued.

Test Plan:
- Read, B_SIZE=4, RW_ACK 3 cycles after R_REQ, R_VALID for 4 cycles with DQ_IN 0x1111..0x4444 -> R_REQ high for exactly 3 cycles; RD_PUSH×4 with RD_OUT 0x1111..0x4444 in order; DONE once, coincident with the 4th push.
- Write, B_SIZE=8, WD_IN increments from 0xA000, D_REQ high for 8 cycles, then W_VALID×8 -> WD_POP×8; DQ_OUT sequence 0xA000..0xA007; DONE the cycle after the 8th W_VALID; W_REQ low after RW_ACK.
- Write, B_SIZE=2, controller asserts D_REQ 3 times -> WD_POP exactly 2; DQ_OUT holds 0xA001.
- CMD_BSIZE=0 accepted -> ERR one cycle later; R_REQ and W_REQ never assert; CMD_READY stays 1.
- TIMEOUT=16, read issued, RW_ACK never asserted -> R_REQ drops and ERR pulses 16 cycles after entering REQ; no DONE; the next command is accepted.
- RESET_N low during the 2nd read beat -> all outputs 0 and CMD_READY 1 immediately; a fresh read after reset completes normally with exactly B_SIZE pushes.
